// File: rtl/spi_4094_master_pkg.sv
// Shared definitions for the 4094 chain SPI master: FSM state encoding,
// idle (park) levels of the SPI pins and a small sizing helper.
package spi_4094_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT_LO = 2'd1,
        ST_SHIFT_HI = 2'd2,
        ST_STROBE   = 2'd3
    } state_e;

    // Levels the SPI pins rest at whenever no transfer is running.
    localparam logic SPI_CLK_PARK = 1'b1;
    localparam logic MOSI_PARK    = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_half_period_timer.sv
// Restartable down-counter used for SPI half-periods and the strobe width.
// Loading N-1 makes tick_o high on the N-th cycle after the load edge;
// the counter then rests at zero until reloaded.
module spi_half_period_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             tick_o
);

    logic [WIDTH-1:0] cnt_q;

    // Reload on request, otherwise count down and hold at terminal count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/spi_4094_master.sv
// SPI master that shifts one NUM_BITS word (MSB first) into a 4094 chain
// and pulses strobe to latch the chain outputs.
// Optional feature macro: SPI_4094_READBACK_EN -- captures the chain echo
// on miso_i and flags when it differs from the previously written word.
//
// state       | meaning
// ST_IDLE     | pins parked, waiting for start_i
// ST_SHIFT_LO | spi_clk low, MOSI shows current bit, echo sampled at end
// ST_SHIFT_HI | spi_clk high, chain shifts on the rising edge
// ST_STROBE   | strobe high, pins parked, then done pulse
module spi_4094_master
    import spi_4094_master_pkg::*;
#(
    parameter int NUM_BITS    = 32,
    parameter int CLK_DIV     = 2,
    parameter int STROBE_CLKS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start_i,
    input  logic [NUM_BITS-1:0] data_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [NUM_BITS-1:0] rdata_o,
    output logic                mismatch_o,
    output logic                spi_clk_o,
    output logic                spi_mosi_o,
    output logic                strobe_o,
    input  logic                miso_i
);

    localparam int TMAX = max_int(CLK_DIV, STROBE_CLKS);
    localparam int TW   = $clog2(TMAX + 1);
    localparam int CW   = $clog2(NUM_BITS + 1);

    localparam logic [TW-1:0] HALF_LOAD = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] STB_LOAD  = TW'(STROBE_CLKS - 1);

    state_e              state_q;
    logic                busy_q;
    logic                done_q;
    logic                sclk_q;
    logic                mosi_q;
    logic                strobe_q;
    logic [NUM_BITS-1:0] shift_q;
    logic [CW-1:0]       bit_cnt_q;

    logic                tmr_load;
    logic [TW-1:0]       tmr_val;
    logic                tmr_tick;

    // Rotating rather than plain shifting returns the written word to
    // shift_q after NUM_BITS steps, so readback can reuse it as last_q.
    logic [NUM_BITS-1:0] shift_rot;
    logic [CW-1:0]       bit_cnt_nxt;
    logic                last_bit;

    assign shift_rot   = (shift_q << 1) | (shift_q >> (NUM_BITS - 1));
    assign bit_cnt_nxt = bit_cnt_q + CW'(1);
    assign last_bit    = (bit_cnt_nxt == CW'(NUM_BITS));

    // Timer restarts on every state change so each phase gets its full length.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = HALF_LOAD;
        case (state_q)
            ST_IDLE:     tmr_load = start_i;
            ST_SHIFT_LO: tmr_load = tmr_tick;
            ST_SHIFT_HI: begin
                tmr_load = tmr_tick;
                tmr_val  = last_bit ? STB_LOAD : HALF_LOAD;
            end
            default:     tmr_load = 1'b0;
        endcase
    end

    spi_half_period_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .tick_o    (tmr_tick)
    );

    // Transfer sequencer with registered pin outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= SPI_CLK_PARK;
            mosi_q    <= MOSI_PARK;
            strobe_q  <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        shift_q   <= data_i;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        sclk_q    <= 1'b0;
                        mosi_q    <= data_i[NUM_BITS-1];
                        state_q   <= ST_SHIFT_LO;
                    end
                end
                ST_SHIFT_LO: begin
                    if (tmr_tick) begin
                        sclk_q  <= 1'b1;
                        state_q <= ST_SHIFT_HI;
                    end
                end
                ST_SHIFT_HI: begin
                    if (tmr_tick) begin
                        shift_q   <= shift_rot;
                        bit_cnt_q <= bit_cnt_nxt;
                        if (last_bit) begin
                            mosi_q   <= MOSI_PARK;
                            strobe_q <= 1'b1;
                            state_q  <= ST_STROBE;
                        end else begin
                            sclk_q  <= 1'b0;
                            mosi_q  <= shift_rot[NUM_BITS-1];
                            state_q <= ST_SHIFT_LO;
                        end
                    end
                end
                ST_STROBE: begin
                    if (tmr_tick) begin
                        strobe_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef SPI_4094_READBACK_EN
    logic [NUM_BITS-1:0] cap_q;
    logic [NUM_BITS-1:0] rdata_q;
    logic [NUM_BITS-1:0] last_q;
    logic                mismatch_q;
    logic                seen_q;

    // Echo capture just before each rising spi_clk; compare at completion.
    // The chain content is unknown until one full word has been written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_q      <= '0;
            rdata_q    <= '0;
            last_q     <= '0;
            mismatch_q <= 1'b0;
            seen_q     <= 1'b0;
        end else begin
            if (state_q == ST_SHIFT_LO && tmr_tick) begin
                cap_q <= (cap_q << 1) | NUM_BITS'(miso_i);
            end
            if (state_q == ST_STROBE && tmr_tick) begin
                rdata_q    <= cap_q;
                last_q     <= shift_q;
                seen_q     <= 1'b1;
                mismatch_q <= seen_q && (cap_q != last_q);
            end
        end
    end

    assign rdata_o    = rdata_q;
    assign mismatch_o = mismatch_q;
`else
    logic unused_miso;
    assign unused_miso = miso_i;
    assign rdata_o     = '0;
    assign mismatch_o  = 1'b0;
`endif

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign spi_clk_o  = sclk_q;
    assign spi_mosi_o = mosi_q;
    assign strobe_o   = strobe_q;

endmodule

// File: tb/tb_spi_4094_master.sv
// Directed bench for spi_4094_master with an 8-bit 4094 chain model and a
// scoreboard of expected MOSI bits and per-transfer readback results.
// Honours SPI_4094_READBACK_EN the same way the design does.
module tb_spi_4094_master;

    localparam int NB       = 8;
    localparam int CD       = 2;
    localparam int SC       = 4;
    localparam int BUSY_LEN = NB * 2 * CD + SC;
`ifdef SPI_4094_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    typedef struct packed {
        logic [NB-1:0] rdata;
        logic          mm;
    } rec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start_i = 1'b0;
    logic [NB-1:0] data_i = '0;
    logic          busy_o, done_o, mismatch_o, spi_clk_o, spi_mosi_o, strobe_o;
    logic [NB-1:0] rdata_o;
    logic          rnd_bit = 1'b0;
    logic [NB-1:0] sr = '0;
    logic          miso;

    assign miso = RB ? sr[NB-1] : rnd_bit;

    spi_4094_master #(
        .NUM_BITS   (NB),
        .CLK_DIV    (CD),
        .STROBE_CLKS(SC)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start_i   (start_i),
        .data_i    (data_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .rdata_o   (rdata_o),
        .mismatch_o(mismatch_o),
        .spi_clk_o (spi_clk_o),
        .spi_mosi_o(spi_mosi_o),
        .strobe_o  (strobe_o),
        .miso_i    (miso)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    bit   bit_q[$];
    rec_t rec_q[$];

    int   exp_xfers      = 0;
    int   strobes_total  = 0;
    int   dones_total    = 0;
    bit   accepted       = 1'b0;
    logic [NB-1:0] last_wr = '0;

    int busy_cnt = 0, rise_cnt = 0, stb_len = 0;
    logic prev_sclk = 1'b1, prev_strobe = 1'b0, prev_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: chain model, MOSI scoreboard, strobe/busy/done timing.
    always @(negedge clk) begin
        rec_t r;
        if (!reset_n) begin
            prev_sclk   = spi_clk_o;
            prev_strobe = 1'b0;
            prev_done   = 1'b0;
            busy_cnt    = 0;
            rise_cnt    = 0;
            stb_len     = 0;
        end else begin
            rnd_bit = 1'($urandom_range(0, 1));
            if (busy_o) busy_cnt++;
            if (spi_clk_o && !prev_sclk) begin
                rise_cnt++;
                if (bit_q.size() == 0) check("mosi_sb_size", bit_q.size(), 1);
                else check("mosi_bit", spi_mosi_o, bit_q.pop_front());
                sr = {sr[NB-2:0], spi_mosi_o};
            end
            if (strobe_o) stb_len++;
            if (!strobe_o && prev_strobe) begin
                check("strobe_len", stb_len, SC);
                strobes_total++;
                stb_len = 0;
            end
            if (done_o) begin
                check("done_width", prev_done, 0);
                check("busy_len", busy_cnt, BUSY_LEN);
                check("sclk_rises", rise_cnt, NB);
                if (rec_q.size() == 0) check("done_sb_size", rec_q.size(), 1);
                else begin
                    r = rec_q.pop_front();
                    check("rdata", rdata_o, r.rdata);
                    check("mismatch", mismatch_o, r.mm);
                end
                dones_total++;
                busy_cnt = 0;
                rise_cnt = 0;
            end
            prev_sclk   = spi_clk_o;
            prev_strobe = strobe_o;
            prev_done   = done_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_start(input logic [NB-1:0] d);
        rec_t r;
        for (int i = NB - 1; i >= 0; i--) bit_q.push_back(d[i]);
        r.rdata = RB ? sr : '0;
        r.mm    = RB && accepted && (sr != last_wr);
        rec_q.push_back(r);
        accepted = 1'b1;
        last_wr  = d;
        exp_xfers++;
    endtask

    task automatic start_xfer(input logic [NB-1:0] d, input bit expect_accept);
        start_i = 1'b1;
        data_i  = d;
        if (expect_accept) push_start(d);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        data_i  = NB'($urandom);
    endtask

    task automatic wait_done(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (done_o) begin
                got = 1'b1;
                break;
            end
        end
        check(tag, got, 1);
    endtask

    initial begin
        int viol;
        bit got;

        // Reset and park levels
        repeat (3) @(posedge clk);
        #1;
        check("rst_sclk", spi_clk_o, 1);
        check("rst_mosi", spi_mosi_o, 1);
        check("rst_strobe", strobe_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_mismatch", mismatch_o, 0);
        reset_n = 1'b1;
        viol = 0;
        repeat (100) begin
            @(negedge clk);
            if (spi_clk_o !== 1'b1 || spi_mosi_o !== 1'b1 || strobe_o !== 1'b0 ||
                busy_o !== 1'b0 || done_o !== 1'b0) viol++;
        end
        check("park_100", viol, 0);
        tick();

        // Single write of A5
        start_xfer(8'hA5, 1'b1);
        check("busy_rise", busy_o, 1);
        check("first_sclk_low", spi_clk_o, 0);
        check("first_mosi_msb", spi_mosi_o, 1);
        wait_done("done_a5");
        tick();
        check("idle_after_a5", busy_o, 0);

        // Start while busy is ignored; start in the done cycle is taken
        start_xfer(8'h5A, 1'b1);
        repeat (4) tick();
        start_xfer(8'hFF, 1'b0);
        wait_done("done_5a");
        start_i = 1'b1;
        data_i  = 8'h81;
        push_start(8'h81);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        check("b2b_busy", busy_o, 1);
        wait_done("done_81");
        tick();
        check("strobe_count_mid", strobes_total, exp_xfers);

        // Reset in the middle of shifting
        start_xfer(8'h66, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rise_cnt >= 3) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
        end
        check("wait_3_bits", got, 1);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_sclk", spi_clk_o, 1);
        check("abort_mosi", spi_mosi_o, 1);
        check("abort_strobe", strobe_o, 0);
        check("abort_busy", busy_o, 0);
        bit_q.delete();
        rec_q.delete();
        exp_xfers--;
        accepted = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (40) tick();
        check("abort_no_strobe", strobes_total, exp_xfers);
        check("abort_idle", busy_o, 0);

        // Readback sequence (all zero when readback is not built)
        start_xfer(8'h3C, 1'b1);
        wait_done("done_3c");
        tick();
        start_xfer(8'hC3, 1'b1);
        wait_done("done_c3");
        repeat (5) tick();
        check("rb_rdata_hold", rdata_o, RB ? 8'h3C : 8'h00);
        check("rb_mm_hold", mismatch_o, 0);
        sr[2] = ~sr[2];
        start_xfer(8'h0F, 1'b1);
        wait_done("done_0f");
        repeat (5) tick();
        check("rb_corrupt_mm", mismatch_o, RB ? 1 : 0);
        check("rb_corrupt_rdata", rdata_o, RB ? 8'hC7 : 8'h00);

        // Nothing left over
        repeat (60) tick();
        check("final_idle", busy_o, 0);
        check("sb_bits_left", bit_q.size(), 0);
        check("sb_recs_left", rec_q.size(), 0);
        check("strobe_total", strobes_total, exp_xfers);
        check("done_total", dones_total, exp_xfers);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
